// File: rtl/geofence_pkg.sv
// geofence_pkg: shared constants and types for the geofence
// self-test feeder and its set storage.
package geofence_pkg;

    localparam int COORD_W     = 10;
    localparam int PTS_PER_SET = 7;
    localparam int PT_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } feeder_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/geofence_set_mem.sv
// geofence_set_mem: NUM_SETS x 7 point store plus one expected
// verdict per set; synchronous write, combinational read.
module geofence_set_mem
    import geofence_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [SET_W-1:0] wr_set,
    input  logic [PT_W-1:0]  wr_idx,
    input  point_t           wr_pt,
    input  logic             wr_exp,
    input  logic [SET_W-1:0] rd_set,
    input  logic [PT_W-1:0]  rd_idx,
    output point_t           rd_pt,
    input  logic [SET_W-1:0] exp_set,
    output logic             rd_exp
);

    localparam logic [SET_W:0]  SET_LIM = (SET_W+1)'(NUM_SETS);
    localparam logic [PT_W-1:0] IDX_LIM = PT_W'(PTS_PER_SET);

    point_t pts      [NUM_SETS][PTS_PER_SET];
    logic   exp_bits [NUM_SETS];

    logic wr_ok;
    logic rd_ok;
    logic exp_ok;

    assign wr_ok  = ({1'b0, wr_set} < SET_LIM) && (wr_idx < IDX_LIM);
    assign rd_ok  = ({1'b0, rd_set} < SET_LIM) && (rd_idx < IDX_LIM);
    assign exp_ok = ({1'b0, exp_set} < SET_LIM);

    // Store one point; the verdict rides along with the object point
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            pts[wr_set][wr_idx] <= wr_pt;
            if (wr_idx == '0) begin
                exp_bits[wr_set] <= wr_exp;
            end
        end
    end

    // Combinational lookup of the requested point and set verdict
    always_comb begin
        rd_pt  = '0;
        rd_exp = 1'b0;
        if (rd_ok) begin
            rd_pt = pts[rd_set][rd_idx];
        end
        if (exp_ok) begin
            rd_exp = exp_bits[exp_set];
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder: streams stored test sets into the geofence
// checker, owns its reset and scores each verdict.
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int TIMEOUT  = 64,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [SET_W-1:0]   cfg_set,
    input  logic [2:0]         cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic               cfg_exp,
    input  logic [SET_W:0]     num_sets,
    input  logic               start,
    output logic               dut_reset,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               valid,
    input  logic               is_inside,
    output logic               busy,
    output logic               done,
    output logic [SET_W:0]     pass_cnt,
    output logic [SET_W:0]     fail_cnt,
    output logic               timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SET_W:0]   SET_LIM  = (SET_W+1)'(NUM_SETS);
    localparam logic [SET_W:0]   CNT_ONE  = (SET_W+1)'(1);
    localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(PTS_PER_SET - 1);

    feeder_state_t state, state_n;

    logic [SET_W-1:0]   set_ptr, set_ptr_n;
    logic [PT_W-1:0]    pt, pt_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SET_W:0]     run_sets, run_sets_n;
    logic [COORD_W-1:0] x_n, y_n;
    logic [SET_W:0]     pass_n, fail_n;
    logic               terr_n;
    logic               done_n;
    logic               dut_reset_n;

    logic [SET_W-1:0]   rd_set;
    logic [PT_W-1:0]    rd_idx;
    point_t             rd_pt;
    logic               rd_exp;

    logic               start_ok;
    logic [SET_W:0]     next_set;
    logic               more_sets;
    logic               wr_en;

    assign busy      = (state == ST_SEND) || (state == ST_WAIT);
    assign start_ok  = (num_sets != '0) && (num_sets <= SET_LIM);
    assign next_set  = {1'b0, set_ptr} + CNT_ONE;
    assign more_sets = next_set < run_sets;
    assign wr_en     = cfg_we && !busy;

    // Address the point that will be on X/Y after the next edge
    always_comb begin
        rd_set = '0;
        rd_idx = '0;
        unique case (state)
            ST_SEND: begin
                rd_set = set_ptr;
                rd_idx = pt + PT_W'(1);
            end
            ST_WAIT: begin
                rd_set = next_set[SET_W-1:0];
                rd_idx = '0;
            end
            default: begin
                rd_set = '0;
                rd_idx = '0;
            end
        endcase
    end

    geofence_set_mem #(
        .NUM_SETS (NUM_SETS),
        .SET_W    (SET_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_set  (cfg_set),
        .wr_idx  (cfg_idx),
        .wr_pt   ('{x: cfg_x, y: cfg_y}),
        .wr_exp  (cfg_exp),
        .rd_set  (rd_set),
        .rd_idx  (rd_idx),
        .rd_pt   (rd_pt),
        .exp_set (set_ptr),
        .rd_exp  (rd_exp)
    );

    // Next-state, stream and scoring decisions
    always_comb begin
        state_n    = state;
        set_ptr_n  = set_ptr;
        pt_n       = pt;
        cnt_n      = cnt;
        run_sets_n = run_sets;
        x_n        = X;
        y_n        = Y;
        pass_n     = pass_cnt;
        fail_n     = fail_cnt;
        terr_n     = timeout_err;
        done_n     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start && start_ok) begin
                    pass_n     = '0;
                    fail_n     = '0;
                    terr_n     = 1'b0;
                    set_ptr_n  = '0;
                    pt_n       = '0;
                    run_sets_n = num_sets;
                    x_n        = rd_pt.x;
                    y_n        = rd_pt.y;
                    state_n    = ST_SEND;
                end else if (start) begin
                    done_n = 1'b1;
                end
            end
            ST_SEND: begin
                if (pt == PT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT;
                end else begin
                    pt_n = pt + PT_W'(1);
                    x_n  = rd_pt.x;
                    y_n  = rd_pt.y;
                end
            end
            ST_WAIT: begin
                if (valid) begin
                    if (is_inside == rd_exp) begin
                        pass_n = pass_cnt + CNT_ONE;
                    end else begin
                        fail_n = fail_cnt + CNT_ONE;
                    end
                    if (more_sets) begin
                        set_ptr_n = next_set[SET_W-1:0];
                        pt_n      = '0;
                        x_n       = rd_pt.x;
                        y_n       = rd_pt.y;
                        state_n   = ST_SEND;
                    end else begin
                        done_n  = 1'b1;
                        state_n = ST_FINISH;
                    end
                end else if (cnt == CNT_LAST) begin
                    fail_n  = fail_cnt + CNT_ONE;
                    terr_n  = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_FINISH;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        dut_reset_n = !((state_n == ST_SEND) || (state_n == ST_WAIT));
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            set_ptr     <= '0;
            pt          <= '0;
            cnt         <= '0;
            run_sets    <= '0;
            X           <= '0;
            Y           <= '0;
            dut_reset   <= 1'b1;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            set_ptr     <= set_ptr_n;
            pt          <= pt_n;
            cnt         <= cnt_n;
            run_sets    <= run_sets_n;
            X           <= x_n;
            Y           <= y_n;
            dut_reset   <= dut_reset_n;
            done        <= done_n;
            pass_cnt    <= pass_n;
            fail_cnt    <= fail_n;
            timeout_err <= terr_n;
        end
    end

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: scoreboard bench with a behavioural checker
// stub (bounding-box verdict) and a result monitor on done.
module tb_geofence_feeder;

    localparam int NS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_set = '0;
    logic [2:0] cfg_idx = '0;
    logic [9:0] cfg_x = '0;
    logic [9:0] cfg_y = '0;
    logic       cfg_exp = 1'b0;
    logic [4:0] num_sets = '0;
    logic       start = 1'b0;
    logic       dut_reset;
    logic [9:0] X;
    logic [9:0] Y;
    logic       valid;
    logic       is_inside = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] pass_cnt;
    logic [4:0] fail_cnt;
    logic       timeout_err;

    logic real_v = 1'b0;
    logic spur_v = 1'b0;
    assign valid = real_v | spur_v;

    always #5 clk = ~clk;

    geofence_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_set     (cfg_set),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_exp     (cfg_exp),
        .num_sets    (num_sets),
        .start       (start),
        .dut_reset   (dut_reset),
        .X           (X),
        .Y           (Y),
        .valid       (valid),
        .is_inside   (is_inside),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .timeout_err (timeout_err)
    );

    typedef struct { int x; int y; } xy_t;
    typedef struct { int p; int f; int t; bit to; } res_t;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   mx [NS][7];
    int   my [NS][7];
    bit   mexp [NS];
    int   m_pass = 0;
    int   m_fail = 0;
    int   m_terr = 0;
    xy_t  exp_pts [$];
    res_t res_q [$];
    res_t r;

    int n_got = 0;
    int wait_left = 0;
    int got_x [7];
    int got_y [7];
    bit stub_v = 1'b0;
    int lat_max = 5;
    bit mute = 1'b0;
    bit spur_en = 1'b0;
    int t7 = 0;

    function automatic void check(string nm, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endfunction

    // Checker rule: object inside the vertices' bounding box
    function automatic bit bbox(input int px [7], input int py [7]);
        int lx, hx, ly, hy;
        lx = px[1]; hx = px[1]; ly = py[1]; hy = py[1];
        for (int i = 2; i < 7; i++) begin
            if (px[i] < lx) lx = px[i];
            if (px[i] > hx) hx = px[i];
            if (py[i] < ly) ly = py[i];
            if (py[i] > hy) hy = py[i];
        end
        return px[0] >= lx && px[0] <= hx && py[0] >= ly && py[0] <= hy;
    endfunction

    function automatic bit model_verdict(input int s);
        int px [7];
        int py [7];
        for (int i = 0; i < 7; i++) begin
            px[i] = mx[s][i];
            py[i] = my[s][i];
        end
        return bbox(px, py);
    endfunction

    always @(posedge clk) cyc++;

    task automatic sample_point();
        xy_t e;
        if (exp_pts.size() == 0) begin
            check("stray_point", 1, 0);
        end else begin
            e = exp_pts.pop_front();
            check("point_x", int'(X), e.x);
            check("point_y", int'(Y), e.y);
        end
        if (n_got < 7) begin
            got_x[n_got] = int'(X);
            got_y[n_got] = int'(Y);
        end
        n_got++;
        if (n_got == 7) begin
            stub_v = bbox(got_x, got_y);
            wait_left = $urandom_range(0, lat_max);
            t7 = cyc;
        end else if (spur_en && $urandom_range(0, 2) == 0) begin
            spur_v = 1'b1;
        end
    endtask

    // Checker stub: collect 7 points, then answer after a latency
    always @(negedge clk) begin
        spur_v = 1'b0;
        if (dut_reset) begin
            n_got = 0;
            real_v = 1'b0;
        end else if (real_v) begin
            real_v = 1'b0;
            n_got = 0;
            sample_point();
        end else if (n_got < 7) begin
            sample_point();
        end else if (!mute) begin
            if (wait_left == 0) begin
                real_v = 1'b1;
                is_inside = stub_v;
            end else begin
                wait_left--;
            end
        end
    end

    // Result monitor: score the counters on every done pulse
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (res_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                r = res_q.pop_front();
                check("pass_cnt", int'(pass_cnt), r.p);
                check("fail_cnt", int'(fail_cnt), r.f);
                check("timeout_err", int'(timeout_err), r.t);
                check("busy_at_done", int'(busy), 0);
                check("dut_reset_at_done", int'(dut_reset), 1);
                check("points_left", exp_pts.size(), 0);
                if (r.to) check("timeout_latency", cyc - t7, 65);
            end
        end
    end

    task automatic wr(input int s, input int idx, input int x,
                      input int y, input bit e);
        cfg_we = 1'b1;
        cfg_set = 4'(s);
        cfg_idx = 3'(idx);
        cfg_x = 10'(x);
        cfg_y = 10'(y);
        cfg_exp = e;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < 7) begin
            mx[s][idx] = x;
            my[s][idx] = y;
        end
        if (idx == 0) mexp[s] = e;
    endtask

    task automatic load_set(input int s, input int xs [7],
                            input int ys [7], input bit e);
        for (int i = 0; i < 7; i++) wr(s, i, xs[i], ys[i], e);
        wr(s, 7, $urandom_range(0, 1023), $urandom_range(0, 1023), ~e);
    endtask

    task automatic load_rand(input int s);
        int xs [7];
        int ys [7];
        for (int i = 0; i < 7; i++) begin
            xs[i] = $urandom_range(0, 1023);
            ys[i] = $urandom_range(0, 1023);
        end
        load_set(s, xs, ys, 1'($urandom_range(0, 1)));
    endtask

    task automatic push_set(input int s);
        for (int i = 0; i < 7; i++) exp_pts.push_back('{mx[s][i], my[s][i]});
    endtask

    task automatic run(input int n, input bit to, input bit junk);
        if (n >= 1 && n <= NS) begin
            m_pass = 0; m_fail = 0; m_terr = 0;
            if (to) begin
                push_set(0);
                m_fail = 1;
                m_terr = 1;
            end else begin
                for (int s = 0; s < n; s++) begin
                    push_set(s);
                    if (model_verdict(s) == mexp[s]) m_pass++;
                    else m_fail++;
                end
            end
        end
        res_q.push_back('{m_pass, m_fail, m_terr, to});
        num_sets = 5'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < n * 40 + 200 && res_q.size() != 0; c++) begin
            cfg_we = junk && busy && ($urandom_range(0, 3) == 0);
            cfg_set = 4'($urandom_range(0, 15));
            cfg_idx = 3'($urandom_range(0, 7));
            cfg_x = 10'($urandom_range(0, 1023));
            cfg_y = 10'($urandom_range(0, 1023));
            cfg_exp = 1'($urandom_range(0, 1));
            start = junk && busy && ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        start = 1'b0;
        if (res_q.size() != 0) begin
            check("run_no_done", 0, 1);
            res_q.delete();
            exp_pts.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    int hx [7];
    int hy [7];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dut_reset", int'(dut_reset), 1);
        check("rst_x", int'(X), 0);
        check("rst_y", int'(Y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass_cnt), 0);
        check("rst_fail", int'(fail_cnt), 0);
        check("rst_terr", int'(timeout_err), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < NS; s++) load_rand(s);

        hx = '{5, 0, 10, 15, 10, 0, 0};
        hy = '{5, 0, 0, 5, 10, 10, 5};
        load_set(0, hx, hy, 1'b1);
        hx[0] = 20; hy[0] = 20;
        load_set(1, hx, hy, 1'b0);
        hx[0] = 300; hy[0] = 4;
        load_set(2, hx, hy, 1'b1);

        run(1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0);
        run(17, 1'b0, 1'b0);

        mute = 1'b1;
        run(1, 1'b1, 1'b0);
        mute = 1'b0;

        push_set(0);
        push_set(1);
        num_sets = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_dut_reset", int'(dut_reset), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pass", int'(pass_cnt), 0);
        check("midrst_fail", int'(fail_cnt), 0);
        check("midrst_terr", int'(timeout_err), 0);
        check("midrst_x", int'(X), 0);
        reset = 1'b0;
        exp_pts.delete();
        res_q.delete();
        m_pass = 0; m_fail = 0; m_terr = 0;
        @(negedge clk);

        run(3, 1'b0, 1'b0);

        spur_en = 1'b1;
        lat_max = 12;
        run(16, 1'b0, 1'b1);
        for (int it = 0; it < 6; it++) begin
            int k;
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) load_rand($urandom_range(0, 15));
            lat_max = $urandom_range(0, 12);
            run($urandom_range(1, 16), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
